// File: rtl/load_align_unit.sv
// Load alignment unit: one word-aligned memory read per load, then lane select and extension.
// Optional abort of stalled reads when LOAD_TIMEOUT_EN is defined.
module load_align_unit #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    output logic              ld_busy,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              ld_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        signed_q;
    logic        accept;
    logic        illegal;
    logic        ack_done;
    logic        timeout;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] extracted;

    assign accept   = (state_q == StIdle) && ld_req;
    assign ack_done = (state_q == StReq) && mem_ack;
    assign ld_busy  = (state_q != StIdle);
    assign ld_valid = (state_q == StResp);

    always_comb begin
        illegal = 1'b0;
        case (ld_size)
            2'b01:   illegal = ld_addr[0];
            2'b10:   illegal = |ld_addr[1:0];
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q;

    // Fires on the TIMEOUT_CYCLES-th REQ cycle; an ack in that cycle takes priority.
    assign timeout = (state_q == StReq) && !mem_ack &&
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == StReq) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        byte_sel  = mem_rdata[{off_q, 3'b000} +: 8];
        half_sel  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        extracted = mem_rdata;
        case (size_q)
            2'b00:   extracted = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   extracted = {{16{signed_q & half_sel[15]}}, half_sel};
            default: extracted = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ld_req) state_d = illegal ? StResp : StReq;
            StReq:   if (mem_ack || timeout) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            signed_q <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ld_data  <= 32'h0;
            ld_err   <= 1'b0;
        end else begin
            if (accept) begin
                size_q   <= ld_size;
                off_q    <= ld_addr[1:0];
                signed_q <= ld_signed;
                if (illegal) begin
                    ld_data <= 32'h0;
                    ld_err  <= 1'b1;
                end else begin
                    mem_req  <= 1'b1;
                    mem_addr <= {ld_addr[ADDR_W-1:2], 2'b00};
                end
            end
            if (ack_done) begin
                ld_data <= extracted;
                ld_err  <= 1'b0;
                mem_req <= 1'b0;
            end else if (timeout) begin
                ld_data <= 32'h0;
                ld_err  <= 1'b1;
                mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit; define LOAD_TIMEOUT_EN to also exercise the timeout path.
module tb_load_align_unit;

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned TMO      = 4;
    localparam int          LW_DELAY = 2;
`else
    localparam int unsigned TMO      = 255;
    localparam int          LW_DELAY = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic        ld_busy;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_align_unit #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_size   (ld_size),
        .ld_signed (ld_signed),
        .ld_busy   (ld_busy),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_err    (ld_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        ld_req    = 1'b1;
        ld_addr   = addr;
        ld_size   = size;
        ld_signed = sgn;
        step();
        ld_req    = 1'b0;
        ld_addr   = 32'hA5A5_A5A5;
        ld_size   = 2'b11;
    endtask

    task automatic legal_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] rdata, input int delay,
                              input logic [31:0] exp_data);
        issue(addr, size, sgn);
        check({tag, " busy"}, ld_busy, 1);
        for (int i = 0; i <= delay; i++) begin
            check({tag, " mem_req"}, mem_req, 1);
            check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
            check({tag, " no early valid"}, ld_valid, 0);
            if (i == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        check({tag, " valid"}, ld_valid, 1);
        check({tag, " data"}, ld_data, exp_data);
        check({tag, " err"}, ld_err, 0);
        check({tag, " req dropped"}, mem_req, 0);
        step();
        check({tag, " valid pulse"}, ld_valid, 0);
        check({tag, " idle"}, ld_busy, 0);
        check({tag, " data held"}, ld_data, exp_data);
    endtask

    task automatic illegal_load(input string tag, input logic [31:0] addr, input logic [1:0] size);
        issue(addr, size, 1'b1);
        check({tag, " valid"}, ld_valid, 1);
        check({tag, " err"}, ld_err, 1);
        check({tag, " data"}, ld_data, 0);
        check({tag, " no mem_req"}, mem_req, 0);
        step();
        check({tag, " valid pulse"}, ld_valid, 0);
        check({tag, " idle"}, ld_busy, 0);
        check({tag, " still no mem_req"}, mem_req, 0);
        check({tag, " err held"}, ld_err, 1);
    endtask

    initial begin
        rst       = 1'b1;
        ld_req    = 1'b0;
        ld_addr   = 32'h0;
        ld_size   = 2'b00;
        ld_signed = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        step();
        step();
        check("rst busy", ld_busy, 0);
        check("rst valid", ld_valid, 0);
        check("rst err", ld_err, 0);
        check("rst data", ld_data, 0);
        check("rst mem_req", mem_req, 0);
        check("rst mem_addr", mem_addr, 0);
        rst = 1'b0;
        step();

        legal_load("lb 1003", 32'h1003, 2'b00, 1'b1, 32'h80FF_7F01, 0, 32'hFFFF_FF80);
        legal_load("lbu 1001", 32'h1001, 2'b00, 1'b0, 32'h80FF_7F01, 1, 32'h0000_007F);
        legal_load("lb 1002", 32'h1002, 2'b00, 1'b1, 32'h80FF_7F01, 0, 32'hFFFF_FFFF);
        legal_load("lbu 1002", 32'h1002, 2'b00, 1'b0, 32'h80FF_7F01, 0, 32'h0000_00FF);
        legal_load("lhu 2002", 32'h2002, 2'b01, 1'b0, 32'h9ABC_1234, 0, 32'h0000_9ABC);
        legal_load("lh 2002", 32'h2002, 2'b01, 1'b1, 32'h9ABC_1234, 0, 32'hFFFF_9ABC);
        legal_load("lh 2000", 32'h2000, 2'b01, 1'b1, 32'h9ABC_1234, 0, 32'h0000_1234);
        legal_load("lh neg lo", 32'h2000, 2'b01, 1'b1, 32'h0000_8001, 0, 32'hFFFF_8001);
        legal_load("lw 3000", 32'h3000, 2'b10, 1'b0, 32'hDEAD_BEEF, LW_DELAY, 32'hDEAD_BEEF);
        legal_load("lw signed", 32'h3004, 2'b10, 1'b1, 32'h8000_0000, 0, 32'h8000_0000);

        illegal_load("lh 0001", 32'h0001, 2'b01);
        illegal_load("lw 0002", 32'h0002, 2'b10);
        illegal_load("size 11", 32'h0000, 2'b11);

        // Stray ack while idle must not produce a result.
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        step();
        mem_ack = 1'b0;
        check("idle ack valid", ld_valid, 0);
        check("idle ack busy", ld_busy, 0);

        // Second request while busy is dropped.
        issue(32'h4000, 2'b10, 1'b0);
        ld_req  = 1'b1;
        ld_addr = 32'h5004;
        ld_size = 2'b00;
        step();
        ld_req = 1'b0;
        check("busy mem_addr", mem_addr, 32'h4000);
        check("busy mem_req", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        step();
        mem_ack = 1'b0;
        check("busy valid", ld_valid, 1);
        check("busy data", ld_data, 32'h1122_3344);
        step();
        check("busy not queued", ld_busy, 0);
        step();
        check("busy no mem_req", mem_req, 0);

        // Reset mid-REQ abandons the transaction.
        issue(32'h6000, 2'b10, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst mid mem_req", mem_req, 0);
        check("rst mid busy", ld_busy, 0);
        check("rst mid valid", ld_valid, 0);
        check("rst mid data", ld_data, 0);
        check("rst mid mem_addr", mem_addr, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        check("rst late ack valid", ld_valid, 0);
        legal_load("lbu 0000", 32'h0000, 2'b00, 1'b0, 32'h0000_00F0, 0, 32'h0000_00F0);

`ifdef LOAD_TIMEOUT_EN
        issue(32'h7000, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("tmo mem_req", mem_req, 1);
            check("tmo no early valid", ld_valid, 0);
            step();
        end
        check("tmo req dropped", mem_req, 0);
        check("tmo valid", ld_valid, 1);
        check("tmo err", ld_err, 1);
        check("tmo data", ld_data, 0);
        step();
        check("tmo valid pulse", ld_valid, 0);
        check("tmo idle", ld_busy, 0);
        legal_load("ack 4th", 32'h7004, 2'b10, 1'b0, 32'hCAFE_F00D, 3, 32'hCAFE_F00D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
